// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// Module : vedic_pkg
// Brief  : Shared state encoding and sizing helpers for vedic_mult_seq.
// Rev    : 1.0
// ============================================================================
package vedic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CORE_WAIT = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counters stay at least one bit wide so the N=1 build still elaborates.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vedic_core.sv
`default_nettype none
// ============================================================================
// Module : vedic_core
// Brief  : Recursive combinational Urdhva-Tiryagbhyam multiplier, exact 2*DIGIT output.
// Rev    : 1.0
// ============================================================================
module vedic_core #(
  parameter int DIGIT = 16
) (
  input  logic [DIGIT-1:0]   a_i,
  input  logic [DIGIT-1:0]   b_i,
  output logic [2*DIGIT-1:0] p_o
);

  generate
    if (DIGIT == 2) begin : g_leaf
      logic w_c;
      assign w_c    = (a_i[1] & b_i[0]) & (a_i[0] & b_i[1]);
      assign p_o[0] = a_i[0] & b_i[0];
      assign p_o[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
      assign p_o[2] = (a_i[1] & b_i[1]) ^ w_c;
      assign p_o[3] = (a_i[1] & b_i[1]) & w_c;
    end else begin : g_split
      localparam int H = DIGIT / 2;
      logic [DIGIT-1:0] w_ll;
      logic [DIGIT-1:0] w_lh;
      logic [DIGIT-1:0] w_hl;
      logic [DIGIT-1:0] w_hh;
      logic [DIGIT:0]   w_mid;

      vedic_core #(.DIGIT(H)) u_ll (.a_i(a_i[H-1:0]),     .b_i(b_i[H-1:0]),     .p_o(w_ll));
      vedic_core #(.DIGIT(H)) u_lh (.a_i(a_i[H-1:0]),     .b_i(b_i[DIGIT-1:H]), .p_o(w_lh));
      vedic_core #(.DIGIT(H)) u_hl (.a_i(a_i[DIGIT-1:H]), .b_i(b_i[H-1:0]),     .p_o(w_hl));
      vedic_core #(.DIGIT(H)) u_hh (.a_i(a_i[DIGIT-1:H]), .b_i(b_i[DIGIT-1:H]), .p_o(w_hh));

      // Cross terms carry one extra bit before being folded in at weight 2^H.
      assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
      assign p_o   = {w_hh, w_ll} + ({{(DIGIT-1){1'b0}}, w_mid} << H);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vedic_mult_seq.sv
`default_nettype none
// ============================================================================
// Module : vedic_mult_seq
// Brief  : Multi-cycle WIDTH x WIDTH multiplier reusing one DIGIT x DIGIT Vedic core.
//          Define VEDIC_MULT_REG_CORE_EN to register the core output (+1 cycle latency).
// Rev    : 1.0
// ============================================================================
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  state_e                     state_q, state_d;
  logic                       en_q;
  logic [N-1:0][DIGIT-1:0]    ra_q, ra_d;
  logic [N-1:0][DIGIT-1:0]    rb_q, rb_d;
  logic [PW-1:0]              acc_q, acc_d;
  logic [CW-1:0]              i_q, i_d;
  logic [CW-1:0]              j_q, j_d;

  logic                       w_accept;
  logic                       w_last_ij;
  logic                       w_issue;
  logic                       w_acc_en;
  logic [2*DIGIT-1:0]         w_core_p;
  logic [SW-1:0]              w_shamt;
  logic [PW-1:0]              w_term;

  vedic_core #(.DIGIT(DIGIT)) u_core (
    .a_i (ra_q[j_q]),
    .b_i (rb_q[i_q]),
    .p_o (w_core_p)
  );

  assign w_accept  = in_valid_i & in_ready_o;
  assign w_last_ij = (i_q == C_LAST) && (j_q == C_LAST);
  assign w_shamt   = SW'((32'(i_q) + 32'(j_q)) * DIGIT);

`ifdef VEDIC_MULT_REG_CORE_EN
  logic [2*DIGIT-1:0] prod_q, prod_d;
  logic [SW-1:0]      shamt_q, shamt_d;
  logic               drain_q, drain_d;

  // The core is fed one cycle ahead of the adder; drain_q marks the last term in flight.
  assign w_issue  = ((state_q == ST_CORE_WAIT) || ((state_q == ST_RUN) && !drain_q)) && !abort_i;
  assign w_acc_en = (state_q == ST_RUN) && !abort_i;
  assign w_term   = PW'(prod_q) << shamt_q;

  always_comb begin
    prod_d  = prod_q;
    shamt_d = shamt_q;
    drain_d = drain_q;
    if (w_accept) begin
      drain_d = 1'b0;
    end else if (w_issue) begin
      prod_d  = w_core_p;
      shamt_d = w_shamt;
      drain_d = w_last_ij;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      shamt_q <= '0;
      drain_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      shamt_q <= shamt_d;
      drain_q <= drain_d;
    end
  end
`else
  assign w_issue  = (state_q == ST_RUN) && !abort_i;
  assign w_acc_en = w_issue;
  assign w_term   = PW'(w_core_p) << w_shamt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef VEDIC_MULT_REG_CORE_EN
          state_d = ST_CORE_WAIT;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_CORE_WAIT: state_d = ST_RUN;
      ST_RUN: begin
`ifdef VEDIC_MULT_REG_CORE_EN
        if (drain_q) state_d = ST_DONE;
`else
        if (w_last_ij) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    in_ready_o  = en_q && (state_q == ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    out_valid_o = (state_q == ST_DONE);
    p_o         = acc_q;
  end

  always_comb begin
    ra_d  = ra_q;
    rb_d  = rb_q;
    acc_d = acc_q;
    i_d   = i_q;
    j_d   = j_q;
    if (w_accept) begin
      ra_d  = a_i;
      rb_d  = b_i;
      acc_d = '0;
      i_d   = '0;
      j_d   = '0;
    end else begin
      if (w_acc_en) acc_d = acc_q + w_term;
      if (w_issue) begin
        if (j_q == C_LAST) begin
          j_d = '0;
          i_d = (i_q == C_LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
    end
  end

  // en_q keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      ra_q  <= '0;
      rb_q  <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      en_q  <= 1'b1;
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      acc_q <= acc_d;
      i_q   <= i_d;
      j_q   <= j_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vedic_mult_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_vedic_mult_seq
// Brief  : Directed bench for vedic_mult_seq with 8/4, 64/16 and 8/8 instances.
// Rev    : 1.0
// ============================================================================
module tb_vedic_mult_seq;

`ifdef VEDIC_MULT_REG_CORE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk;
  logic rst_n;
  int   sel;
  int   n_tests;
  int   n_fail;

  logic        g_valid;
  logic [63:0] g_a;
  logic [63:0] g_b;
  logic        g_abort;
  logic        g_out_ready;

  logic         s8_in_ready, s8_busy, s8_out_valid;
  logic [15:0]  s8_p;
  logic         s64_in_ready, s64_busy, s64_out_valid;
  logic [127:0] s64_p;
  logic         s1_in_ready, s1_busy, s1_out_valid;
  logic [15:0]  s1_p;

  logic         cur_ready, cur_busy, cur_valid;
  logic [127:0] cur_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vedic_mult_seq #(.WIDTH(8), .DIGIT(4)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (g_valid && sel == 0),
    .in_ready_o  (s8_in_ready),
    .a_i         (g_a[7:0]),
    .b_i         (g_b[7:0]),
    .abort_i     (g_abort && sel == 0),
    .busy_o      (s8_busy),
    .out_valid_o (s8_out_valid),
    .out_ready_i (g_out_ready || sel != 0),
    .p_o         (s8_p)
  );

  vedic_mult_seq #(.WIDTH(64), .DIGIT(16)) u_dut64 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (g_valid && sel == 1),
    .in_ready_o  (s64_in_ready),
    .a_i         (g_a),
    .b_i         (g_b),
    .abort_i     (g_abort && sel == 1),
    .busy_o      (s64_busy),
    .out_valid_o (s64_out_valid),
    .out_ready_i (g_out_ready || sel != 1),
    .p_o         (s64_p)
  );

  vedic_mult_seq #(.WIDTH(8), .DIGIT(8)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (g_valid && sel == 2),
    .in_ready_o  (s1_in_ready),
    .a_i         (g_a[7:0]),
    .b_i         (g_b[7:0]),
    .abort_i     (g_abort && sel == 2),
    .busy_o      (s1_busy),
    .out_valid_o (s1_out_valid),
    .out_ready_i (g_out_ready || sel != 2),
    .p_o         (s1_p)
  );

  always_comb begin
    cur_ready = s8_in_ready;
    cur_busy  = s8_busy;
    cur_valid = s8_out_valid;
    cur_p     = 128'(s8_p);
    case (sel)
      1: begin
        cur_ready = s64_in_ready;
        cur_busy  = s64_busy;
        cur_valid = s64_out_valid;
        cur_p     = s64_p;
      end
      2: begin
        cur_ready = s1_in_ready;
        cur_busy  = s1_busy;
        cur_valid = s1_out_valid;
        cur_p     = 128'(s1_p);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair and wait for out_valid (product is left in DONE).
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp, input int lat_exp, input bit abort_on_accept);
    int lat;
    bit rdy_low;
    lat = 0;
    while (!cur_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " ready"}, 128'(cur_ready), 128'(1));
    g_valid = 1'b1;
    g_a     = a;
    g_b     = b;
    g_abort = abort_on_accept;
    @(negedge clk);
    g_valid = 1'b0;
    g_abort = 1'b0;
    g_a     = ~a;
    g_b     = ~b;
    check({tag, " busy"}, 128'(cur_busy), 128'(1));
    lat     = 0;
    rdy_low = 1'b1;
    while (!cur_valid && lat < 200) begin
      if (cur_ready) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(lat_exp + EXTRA));
    check({tag, " in_ready low"}, 128'(rdy_low), 128'(1));
    check({tag, " p"}, cur_p, exp);
  endtask

  task automatic finish_op(input string tag);
    g_out_ready = 1'b1;
    @(negedge clk);
    g_out_ready = 1'b0;
    check({tag, " out_valid drop"}, 128'(cur_valid), 128'(0));
    check({tag, " in_ready next"}, 128'(cur_ready), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    sel         = 0;
    rst_n       = 1'b0;
    g_valid     = 1'b0;
    g_a         = '0;
    g_b         = '0;
    g_abort     = 1'b0;
    g_out_ready = 1'b0;

    #1;
    check("rst in_ready", 128'(s8_in_ready), 128'(0));
    check("rst out_valid", 128'(s8_out_valid), 128'(0));
    check("rst busy", 128'(s64_busy), 128'(0));
    check("rst p", s64_p, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", 128'(s8_in_ready), 128'(1));

    // WIDTH=8, DIGIT=4 basic products
    run_op("ff*ff", 64'hFF, 64'hFF, 128'hFE01, 4, 1'b0);
    finish_op("ff*ff");
    run_op("80*02", 64'h80, 64'h02, 128'h0100, 4, 1'b0);
    finish_op("80*02");
    run_op("0f*f0", 64'h0F, 64'hF0, 128'h0E10, 4, 1'b0);
    finish_op("0f*f0");

    // Backpressure: product held stable for 10 stalled cycles
    run_op("bp", 64'h0D, 64'h0B, 128'h008F, 4, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp hold valid", 128'(cur_valid), 128'(1));
      check("bp hold p", cur_p, 128'h008F);
    end
    finish_op("bp");

    // Abort on the second RUN cycle, no product afterwards
    check("abort pre ready", 128'(cur_ready), 128'(1));
    g_valid = 1'b1;
    g_a     = 64'h12;
    g_b     = 64'h34;
    @(negedge clk);
    g_valid = 1'b0;
    @(negedge clk);
    g_abort = 1'b1;
    @(negedge clk);
    g_abort = 1'b0;
    check("abort idle ready", 128'(cur_ready), 128'(1));
    check("abort idle busy", 128'(cur_busy), 128'(0));
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (cur_valid) seen = 1'b1;
        @(negedge clk);
      end
      check("abort no out_valid", 128'(seen), 128'(0));
    end
    run_op("post-abort 3*5", 64'd3, 64'd5, 128'd15, 4, 1'b0);
    finish_op("post-abort 3*5");

    // Abort in IDLE is ignored and the operands are taken
    run_op("idle abort", 64'h07, 64'h09, 128'd63, 4, 1'b1);
    finish_op("idle abort");

    // WIDTH=64, DIGIT=16
    sel = 1;
    @(negedge clk);
    run_op("64 max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 16, 1'b0);
    finish_op("64 max");
    run_op("64 a0", 64'd0, 64'hDEAD_BEEF_0123_4567, 128'd0, 16, 1'b0);
    finish_op("64 a0");
    run_op("64 b0", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 128'd0, 16, 1'b0);
    finish_op("64 b0");

    // Asynchronous reset in the middle of RUN
    g_valid = 1'b1;
    g_a     = 64'h1234_5678_9ABC_DEF0;
    g_b     = 64'h0FED_CBA9_8765_4321;
    @(negedge clk);
    g_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-rst busy", 128'(s64_busy), 128'(0));
    check("mid-rst out_valid", 128'(s64_out_valid), 128'(0));
    check("mid-rst in_ready", 128'(s64_in_ready), 128'(0));
    check("mid-rst p", s64_p, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("64 post-rst", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0001,
           128'h0000_0000_0000_0001_0000_0001_0000_0000, 16, 1'b0);
    finish_op("64 post-rst");

    // N=1: DIGIT equals WIDTH
    sel = 2;
    @(negedge clk);
    run_op("n1 ab*cd", 64'hAB, 64'hCD, 128'h88EF, 1, 1'b0);
    finish_op("n1 ab*cd");
    run_op("n1 ff*ff", 64'hFF, 64'hFF, 128'hFE01, 1, 1'b0);
    finish_op("n1 ff*ff");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
